gate_out_monitor: RTL
=====================

Name: gate_out_monitor

Overview:
- Downstream consumer of the registered two-output gate stage: samples its out1/out2 lines as in_a/in_b.
- Counts rising edges on each line with saturating counters.
- Detects the ordered event "in_a rises, then in_b rises within WINDOW cycles".
- Offers a valid/ack snapshot port so a slower reader can capture both counts atomically.

Parameters:
- CNT_W, 8, width of each edge counter and snapshot field.
- WINDOW, 4, max cycles after an in_a rise in which an in_b rise produces a match; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- in_a  input  1  upstream out1.
- in_b  input  1  upstream out2.
- clr  input  1  synchronous clear of cnt_a/cnt_b.
- snap_req  input  1  request a counter snapshot.
- snap_ack  input  1  reader accepts the held snapshot.
- cnt_a  output  CNT_W  live in_a rising-edge count.
- cnt_b  output  CNT_W  live in_b rising-edge count.
- match  output  1  one-cycle pulse on a detected a-then-b sequence.
- snap_valid  output  1  snapshot held and stable.
- snap_a  output  CNT_W  captured cnt_a.
- snap_b  output  CNT_W  captured cnt_b.

Behaviour:
- Reset:
  - rst=1 at a posedge forces cnt_a=cnt_b=0, match=0, snap_valid=0, snap_a=snap_b=0.
  - FSM goes to IDLE, timer=0, prev_a=prev_b=0.
  - Reset is valid mid-sequence and mid-handshake; it overrides every other input.
- Edge detect:
  - prev_a/prev_b register in_a/in_b each cycle.
  - rise_a = in_a & ~prev_a (same for rise_b).
  - Because prev resets to 0, an input already high in the first cycle after reset counts as one rise.
- Counters:
  - On rise_a, cnt_a increments; the new value is visible the next cycle. Same for cnt_b.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - clr=1 sets both counters to 0 next cycle and wins over a simultaneous rise.
  - clr does not affect the FSM or the snapshot.
- Sequence FSM (states IDLE, ARMED):
  - IDLE:
    - rise_a -> ARMED, timer=1.
    - A simultaneous rise_b in the same cycle does not match; b must follow a strictly.
  - ARMED:
    - rise_b -> match=1 on the next cycle, go to IDLE. This holds even if rise_a occurs in the same cycle.
    - Otherwise, rise_a restarts the window (timer=1).
    - Otherwise, timer==WINDOW -> IDLE with no match.
    - Otherwise, timer increments.
  - Net effect: rise_b 1..WINDOW cycles after the latest rise_a matches.
  - match is registered and high for exactly one cycle per detection.
- Snapshot handshake:
  - snap_req=1 while snap_valid=0: next cycle snap_valid=1, snap_a/snap_b = cnt_a/cnt_b as registered in the request cycle (pre-increment).
  - While snap_valid=1, snap_a/snap_b are held stable and snap_req is ignored.
  - snap_ack=1 while snap_valid=1: snap_valid=0 next cycle. snap_req in that same cycle is ignored; the reader must re-request.
  - snap_ack while snap_valid=0 has no effect.
- Latency: in_* sample to counter/match update is 1 cycle; snap_req to snap_valid is 1 cycle.

Optional Feature:
- Macro: GATE_MON_MATCH_COUNT_EN.
- Defined:
  - Adds output match_cnt, width CNT_W, reset 0, cleared by clr.
  - Saturating increment on each match pulse.
  - The snapshot adds a snap_m field captured under the same rules as snap_a/snap_b.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, inputs 0 -> all outputs 0; in_a held 1 after reset -> cnt_a=1 next cycle, not incremented while held.
- Saturation: CNT_W=4, 20 pulses on in_a -> cnt_a stops at 15; clr with a simultaneous rise -> cnt_a=0.
- Match window, WINDOW=4:
  - in_a rises at t0, in_b rises at t0+3 -> match=1 at t0+4 for one cycle.
  - in_b at t0+5 -> no match.
  - Simultaneous a/b rise from IDLE -> no match.
- Re-arm: in_a rises at t0 and t0+3, in_b rises at t0+6 -> match=1 at t0+7.
- Snapshot: cnt_a=5, snap_req -> snap_valid=1, snap_a=5. Further in_a rises leave snap_a=5 while cnt_a climbs. snap_ack -> snap_valid=0 next cycle. snap_req with ack in the same cycle is ignored.
- Reset mid-operation: assert rst while ARMED and snap_valid=1 -> next cycle FSM in IDLE (a following in_b rise gives no match), snap_valid=0, counters 0.

Source files
------------

// File: rtl/gate_out_monitor_if.sv
// Snapshot handshake bundle between gate_out_monitor (slave) and a slower reader (master).
// With GATE_MON_MATCH_COUNT_EN defined the bundle also carries the captured match count.
interface gate_out_monitor_if #(
  parameter int CNT_W = 8
);
  logic             snap_req;
  logic             snap_ack;
  logic             snap_valid;
  logic [CNT_W-1:0] snap_a;
  logic [CNT_W-1:0] snap_b;
`ifdef GATE_MON_MATCH_COUNT_EN
  logic [CNT_W-1:0] snap_m;

  modport master (output snap_req, snap_ack, input snap_valid, snap_a, snap_b, snap_m);
  modport slave  (input snap_req, snap_ack, output snap_valid, snap_a, snap_b, snap_m);
`else
  modport master (output snap_req, snap_ack, input snap_valid, snap_a, snap_b);
  modport slave  (input snap_req, snap_ack, output snap_valid, snap_a, snap_b);
`endif
endinterface

// File: rtl/gate_out_monitor.sv
// Edge counters, a-then-b sequence detector and atomic snapshot port for the gate stage outputs.
// Optional GATE_MON_MATCH_COUNT_EN adds a saturating match counter and its snapshot field.
module gate_out_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             match,
`ifdef GATE_MON_MATCH_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  gate_out_monitor_if.slave snap
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       WIN_C    = 8'(WINDOW);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_ARMED = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic             prev_a_q, prev_b_q;
  logic             rise_a_s, rise_b_s;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [0:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             match_q, match_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
`ifdef GATE_MON_MATCH_COUNT_EN
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] snap_m_q, snap_m_d;
`endif

  assign rise_a_s = in_a & ~prev_a_q;
  assign rise_b_s = in_b & ~prev_b_q;

  // Edge counters: clear beats a simultaneous rise, increments saturate.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      cnt_a_d = rise_a_s ? sat_inc(cnt_a_q) : cnt_a_q;
      cnt_b_d = rise_b_s ? sat_inc(cnt_b_q) : cnt_b_q;
    end
  end

  // Sequence detector: a b-rise takes priority over a re-arming a-rise while armed.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    match_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_a_s) begin
          state_d = ST_ARMED;
          timer_d = 8'd1;
        end else begin
          state_d = ST_IDLE;
          timer_d = 8'd0;
        end
      end
      ST_ARMED: begin
        if (rise_b_s) begin
          match_d = 1'b1;
          state_d = ST_IDLE;
          timer_d = 8'd0;
        end else if (rise_a_s) begin
          timer_d = 8'd1;
        end else if (timer_q == WIN_C) begin
          state_d = ST_IDLE;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 8'd0;
      end
    endcase
  end

  // Snapshot handshake: capture only from the empty state, release only on ack.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
`ifdef GATE_MON_MATCH_COUNT_EN
    snap_m_d     = snap_m_q;
`endif
    if (!snap_valid_q && snap.snap_req) begin
      snap_valid_d = 1'b1;
      snap_a_d     = cnt_a_q;
      snap_b_d     = cnt_b_q;
`ifdef GATE_MON_MATCH_COUNT_EN
      snap_m_d     = match_cnt_q;
`endif
    end else if (snap_valid_q && snap.snap_ack) begin
      snap_valid_d = 1'b0;
    end else begin
      snap_valid_d = snap_valid_q;
    end
  end

`ifdef GATE_MON_MATCH_COUNT_EN
  // Match counter advances on each registered match pulse.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (clr) begin
      match_cnt_d = '0;
    end else if (match_q) begin
      match_cnt_d = sat_inc(match_cnt_q);
    end else begin
      match_cnt_d = match_cnt_q;
    end
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_q     <= 1'b0;
      prev_b_q     <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      match_q      <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
`ifdef GATE_MON_MATCH_COUNT_EN
      match_cnt_q  <= '0;
      snap_m_q     <= '0;
`endif
    end else begin
      prev_a_q     <= in_a;
      prev_b_q     <= in_b;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      match_q      <= match_d;
      snap_valid_q <= snap_valid_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
`ifdef GATE_MON_MATCH_COUNT_EN
      match_cnt_q  <= match_cnt_d;
      snap_m_q     <= snap_m_d;
`endif
    end
  end

  assign cnt_a           = cnt_a_q;
  assign cnt_b           = cnt_b_q;
  assign match           = match_q;
  assign snap.snap_valid = snap_valid_q;
  assign snap.snap_a     = snap_a_q;
  assign snap.snap_b     = snap_b_q;
`ifdef GATE_MON_MATCH_COUNT_EN
  assign match_cnt       = match_cnt_q;
  assign snap.snap_m     = snap_m_q;
`endif

endmodule
